regfile_bypass: RTL

Register file and in-flight write scoreboard that is the receiving end of the write-back interface. It holds eight 16-bit general registers, takes one write per cycle from the write-back stage, and serves two combinational read ports to decode, with a write-to-read bypass so a value written this cycle is readable this cycle. A per-register pending-write counter tells decode when a source operand is still owed by an older instruction, so decode can stall.

---
 rtl/regfile_bypass_pkg.sv | 10 +
 rtl/pend_ctr.sv | 35 +++
 rtl/regfile_bypass.sv | 82 ++++++++
 3 files changed

// File: rtl/regfile_bypass_pkg.sv
// Shared sizing constants for the register file and its pending-write scoreboard.
package regfile_bypass_pkg;

  localparam int DATA_W   = 16;
  localparam int REG_N    = 8;
  localparam int SEL_W    = $clog2(REG_N);
  localparam int PEND_W   = 2;
  localparam int PEND_MAX = 3;

endpackage

// File: rtl/pend_ctr.sv
// Saturating up/down counter that tracks the in-flight writes owed to one register.
module pend_ctr #(
  parameter int PEND_W   = regfile_bypass_pkg::PEND_W,
  parameter int PEND_MAX = regfile_bypass_pkg::PEND_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec,
  output logic [PEND_W-1:0] count,
  output logic              err_pulse
);

  localparam logic [PEND_W-1:0] MAX_V = PEND_W'(PEND_MAX);

  logic inc_only;
  logic dec_only;

  always_comb begin
    inc_only  = inc && !dec;
    dec_only  = dec && !inc;
    err_pulse = (inc_only && (count == MAX_V)) || (dec_only && (count == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc_only && (count != MAX_V)) begin
      count <= count + 1'b1;
    end else if (dec_only && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/regfile_bypass.sv
// Eight-entry register file with write-to-read bypass and a per-register
// pending-write scoreboard that drives the decode stall.
module regfile_bypass #(
  parameter int DATA_W = regfile_bypass_pkg::DATA_W,
  parameter int REG_N  = regfile_bypass_pkg::REG_N,
  parameter int PEND_W = regfile_bypass_pkg::PEND_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     writeEn,
  input  logic [$clog2(REG_N)-1:0] writeRegSel,
  input  logic [DATA_W-1:0]        writeData,
  input  logic                     read1En,
  input  logic [$clog2(REG_N)-1:0] read1RegSel,
  output logic [DATA_W-1:0]        read1Data,
  input  logic                     read2En,
  input  logic [$clog2(REG_N)-1:0] read2RegSel,
  output logic [DATA_W-1:0]        read2Data,
  input  logic                     issueEn,
  input  logic [$clog2(REG_N)-1:0] issueRegSel,
  output logic                     stall,
  output logic                     err
);

  import regfile_bypass_pkg::*;

  localparam int SW = $clog2(REG_N);
  localparam logic [PEND_W-1:0] ONE = PEND_W'(1);

  logic [DATA_W-1:0] regs [REG_N];
  logic [PEND_W-1:0] pend [REG_N];
  logic [REG_N-1:0]  err_vec;

  logic wr_hit1;
  logic wr_hit2;
  logic ready1;
  logic ready2;

  for (genvar g = 0; g < REG_N; g++) begin : g_pend
    pend_ctr #(
      .PEND_W  (PEND_W),
      .PEND_MAX((1 << PEND_W) - 1)
    ) u_pend_ctr (
      .clk      (clk),
      .rst      (rst),
      .inc      (issueEn && (issueRegSel == SW'(g))),
      .dec      (writeEn && (writeRegSel == SW'(g))),
      .count    (pend[g]),
      .err_pulse(err_vec[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_N; i++) begin
        regs[i] <= '0;
      end
    end else if (writeEn) begin
      regs[writeRegSel] <= writeData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (|err_vec) begin
      err <= 1'b1;
    end
  end

  // A single owed write that lands this cycle is covered by the bypass, so it does not stall.
  always_comb begin
    wr_hit1   = writeEn && (writeRegSel == read1RegSel);
    wr_hit2   = writeEn && (writeRegSel == read2RegSel);
    read1Data = wr_hit1 ? writeData : regs[read1RegSel];
    read2Data = wr_hit2 ? writeData : regs[read2RegSel];
    ready1    = (pend[read1RegSel] == '0) || ((pend[read1RegSel] == ONE) && wr_hit1);
    ready2    = (pend[read2RegSel] == '0) || ((pend[read2RegSel] == ONE) && wr_hit2);
    stall     = (read1En && !ready1) || (read2En && !ready2);
  end

endmodule
